// File: rtl/bram_equiv_checker.sv
// bram_equiv_checker
// Watches one memory address W and cross-checks reads of it from a reference
// ("gold") and an implementation ("gate") block RAM. Byte lanes of W become
// checkable once a single port has written them; colliding same-cycle writes
// to a lane make it unknown again. Each qualifying read is carried through a
// RD_LATENCY-deep pipeline and compared when its data returns.
//
// Optional feature: define BRAM_CHK_SHADOW_EN to keep a shadow copy of W and
// additionally compare gate read data against the shadow value captured when
// the read was issued.
module bram_equiv_checker #(
  parameter int ABITS      = 10,
  parameter int DBITS      = 36,
  parameter int NPORTS     = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ABITS-1:0]                watch_addr,
  input  logic [NPORTS*ABITS-1:0]         a,
  input  logic [NPORTS-1:0]               we,
  input  logic [NPORTS*((DBITS+7)/8)-1:0] be,
  input  logic [NPORTS*DBITS-1:0]         wd,
  input  logic [NPORTS*DBITS-1:0]         gold_rd,
  input  logic [NPORTS*DBITS-1:0]         gate_rd,
  output logic                            fail,
  output logic [1:0]                      fail_port,
  output logic [15:0]                     err_cnt,
  output logic [15:0]                     chk_cnt
);

  localparam int NB = (DBITS + 7) / 8;

  logic [ABITS-1:0]  w_addr;
  logic [NB-1:0]     vmask;
  logic [NPORTS-1:0] hit_wr;
  logic [NPORTS-1:0] hit_rd;
  logic [NPORTS-1:0] issue;
  logic [NB-1:0]     lane_one;
  logic [NB-1:0]     lane_multi;

  logic              pipe_v [NPORTS][RD_LATENCY];
  logic [NB-1:0]     pipe_m [NPORTS][RD_LATENCY];

  logic [NPORTS-1:0] done;
  logic [NPORTS-1:0] mis;
  logic [2:0]        n_done;
  logic [2:0]        n_mis;
  logic [1:0]        first_port;

  // Expand a lane mask to a bit mask; the top lane may be partial.
  function automatic logic [DBITS-1:0] lane_bits(input logic [NB-1:0] m);
    logic [DBITS-1:0] r;
    r = '0;
    for (int i = 0; i < DBITS; i++) r[i] = m[i/8];
    return r;
  endfunction

  // 16-bit counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [2:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {14'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Classify each port's access as a write or a read of the watched address.
  always_comb begin
    hit_wr = '0;
    hit_rd = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (a[p*ABITS +: ABITS] == w_addr) begin
        if (we[p]) hit_wr[p] = 1'b1;
        else       hit_rd[p] = 1'b1;
      end
    end
  end

  // A read of W is checkable only with no concurrent write to W and some lane known.
  always_comb begin
    issue = '0;
    for (int p = 0; p < NPORTS; p++)
      issue[p] = hit_rd[p] && (hit_wr == '0) && (vmask != '0);
  end

  // Count writers per lane at W: one writer defines the lane, several make it unknown.
  always_comb begin
    lane_one   = '0;
    lane_multi = '0;
    for (int b = 0; b < NB; b++) begin
      logic [2:0] n;
      n = '0;
      for (int p = 0; p < NPORTS; p++)
        if (hit_wr[p] && be[p*NB + b]) n = n + 3'd1;
      lane_one[b]   = (n == 3'd1);
      lane_multi[b] = (n >= 3'd2);
    end
  end

  // Watched address and per-lane valid mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr <= watch_addr;
      vmask  <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (lane_multi[b])    vmask[b] <= 1'b0;
        else if (lane_one[b]) vmask[b] <= 1'b1;
      end
    end
  end

  // Per-port check pipeline carrying the lane mask seen at issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NPORTS; p++)
        for (int s = 0; s < RD_LATENCY; s++) begin
          pipe_v[p][s] <= 1'b0;
          pipe_m[p][s] <= '0;
        end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        pipe_v[p][0] <= issue[p];
        pipe_m[p][0] <= vmask;
        for (int s = 1; s < RD_LATENCY; s++) begin
          pipe_v[p][s] <= pipe_v[p][s-1];
          pipe_m[p][s] <= pipe_m[p][s-1];
        end
      end
    end
  end

`ifdef BRAM_CHK_SHADOW_EN
  logic [DBITS-1:0] shadow;
  logic [DBITS-1:0] shadow_nxt;
  logic [DBITS-1:0] pipe_s [NPORTS][RD_LATENCY];

  // Shadow follows single-writer lane writes to W; collided lanes are masked anyway.
  always_comb begin
    shadow_nxt = shadow;
    for (int p = 0; p < NPORTS; p++)
      for (int i = 0; i < DBITS; i++)
        if (hit_wr[p] && be[p*NB + i/8] && lane_one[i/8])
          shadow_nxt[i] = wd[p*DBITS + i];
  end

  // Shadow word register.
  always_ff @(posedge clk) begin
    if (rst) shadow <= '0;
    else     shadow <= shadow_nxt;
  end

  // Shadow value captured at issue travels alongside the check.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NPORTS; p++)
        for (int s = 0; s < RD_LATENCY; s++) pipe_s[p][s] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        pipe_s[p][0] <= shadow;
        for (int s = 1; s < RD_LATENCY; s++) pipe_s[p][s] <= pipe_s[p][s-1];
      end
    end
  end
`else
  logic wd_unused;
  assign wd_unused = ^wd;
`endif

  // Compare returning read data on the lanes that were known at issue.
  always_comb begin
    done = '0;
    mis  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      logic [DBITS-1:0] diff;
      logic [DBITS-1:0] bits;
      bits = lane_bits(pipe_m[p][RD_LATENCY-1]);
      diff = (gold_rd[p*DBITS +: DBITS] ^ gate_rd[p*DBITS +: DBITS]) & bits;
`ifdef BRAM_CHK_SHADOW_EN
      diff = diff | ((gate_rd[p*DBITS +: DBITS] ^ pipe_s[p][RD_LATENCY-1]) & bits);
`endif
      done[p] = pipe_v[p][RD_LATENCY-1];
      mis[p]  = done[p] && (diff != '0);
    end
  end

  // Per-cycle completion and mismatch counts, plus the lowest mismatching port.
  always_comb begin
    n_done     = '0;
    n_mis      = '0;
    first_port = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (done[p]) n_done = n_done + 3'd1;
      if (mis[p])  n_mis  = n_mis + 3'd1;
    end
    for (int p = NPORTS - 1; p >= 0; p--)
      if (mis[p]) first_port = 2'(p);
  end

  // Status: saturating counters and sticky first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail      <= 1'b0;
      fail_port <= 2'd0;
      err_cnt   <= 16'd0;
      chk_cnt   <= 16'd0;
    end else begin
      chk_cnt <= sat_add(chk_cnt, n_done);
      err_cnt <= sat_add(err_cnt, n_mis);
      if (!fail && (mis != '0)) begin
        fail      <= 1'b1;
        fail_port <= (NPORTS == 1) ? 2'd0 : first_port;
      end
    end
  end

endmodule

// File: tb/tb_bram_equiv_checker.sv
// Randomized and directed bench for bram_equiv_checker (ABITS=4, DBITS=16,
// NPORTS=2, RD_LATENCY=1, watched address 5) against a queue-based model.
module tb_bram_equiv_checker;

  localparam int LAT = 1;

  logic        clk;
  logic        rst;
  logic [3:0]  watch;
  logic [3:0]  a_v    [2];
  logic [1:0]  we_v;
  logic [1:0]  be_v   [2];
  logic [15:0] wd_v   [2];
  logic [15:0] gold_v [2];
  logic [15:0] gate_v [2];

  logic [7:0]  a;
  logic [3:0]  be;
  logic [31:0] wd, gold_rd, gate_rd;
  logic        fail;
  logic [1:0]  fail_port;
  logic [15:0] err_cnt, chk_cnt;

  assign a       = {a_v[1], a_v[0]};
  assign be      = {be_v[1], be_v[0]};
  assign wd      = {wd_v[1], wd_v[0]};
  assign gold_rd = {gold_v[1], gold_v[0]};
  assign gate_rd = {gate_v[1], gate_v[0]};

  bram_equiv_checker #(.ABITS(4), .DBITS(16), .NPORTS(2), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .watch_addr(watch), .a(a), .we(we_v), .be(be),
    .wd(wd), .gold_rd(gold_rd), .gate_rd(gate_rd),
    .fail(fail), .fail_port(fail_port), .err_cnt(err_cnt), .chk_cnt(chk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          port;
    logic [1:0]  mask;
    logic [15:0] shd;
  } chk_t;

  chk_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [3:0]  m_w = 4'h0;
  logic [1:0]  m_vmask = '0;
  logic [15:0] m_shadow = '0;
  int          m_chk = 0, m_err = 0, m_fport = 0;
  logic        m_fail = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit lane_diff(input logic [15:0] x, input logic [15:0] y, input logic [1:0] m);
    for (int b = 0; b < 2; b++)
      if (m[b] && (x[8*b +: 8] != y[8*b +: 8])) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock: update the model from the current inputs, then compare outputs.
  task automatic step();
    int   nd, nm, first, nw, wsel;
    bit   any_w, bad;
    chk_t e;
    nd = 0; nm = 0; first = -1;
    if (rst) begin
      q.delete();
      m_vmask = '0; m_shadow = '0; m_chk = 0; m_err = 0; m_fail = 1'b0; m_fport = 0;
      m_w = watch;
    end else begin
      while (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        nd++;
        bad = lane_diff(gold_v[e.port], gate_v[e.port], e.mask);
`ifdef BRAM_CHK_SHADOW_EN
        bad = bad || lane_diff(e.shd, gate_v[e.port], e.mask);
`endif
        if (bad) begin
          nm++;
          if (first < 0 || e.port < first) first = e.port;
        end
      end
      any_w = 1'b0;
      for (int p = 0; p < 2; p++) if (we_v[p] && a_v[p] == m_w) any_w = 1'b1;
      for (int p = 0; p < 2; p++)
        if (a_v[p] == m_w && !we_v[p] && !any_w && m_vmask != 2'b00) begin
          e.due = cyc + LAT; e.port = p; e.mask = m_vmask; e.shd = m_shadow;
          q.push_back(e);
        end
      for (int b = 0; b < 2; b++) begin
        nw = 0; wsel = 0;
        for (int p = 0; p < 2; p++)
          if (we_v[p] && a_v[p] == m_w && be_v[p][b]) begin nw++; wsel = p; end
        if (nw == 1) begin
          m_vmask[b] = 1'b1;
          m_shadow[8*b +: 8] = wd_v[wsel][8*b +: 8];
        end else if (nw > 1) begin
          m_vmask[b] = 1'b0;
        end
      end
      m_chk = (m_chk + nd > 65535) ? 65535 : m_chk + nd;
      m_err = (m_err + nm > 65535) ? 65535 : m_err + nm;
      if (!m_fail && nm > 0) begin m_fail = 1'b1; m_fport = first; end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("chk_cnt", chk_cnt, m_chk);
    chk("err_cnt", err_cnt, m_err);
    chk("fail", fail, m_fail);
    chk("fail_port", fail_port, m_fport);
  endtask

  task automatic idle();
    rst = 1'b0; watch = 4'h5; we_v = 2'b00;
    for (int p = 0; p < 2; p++) begin
      a_v[p] = 4'h0; be_v[p] = 2'b00; wd_v[p] = '0; gold_v[p] = '0; gate_v[p] = '0;
    end
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic write0(input logic [1:0] bev, input logic [15:0] d);
    idle(); a_v[0] = 4'h5; we_v[0] = 1'b1; be_v[0] = bev; wd_v[0] = d; step();
  endtask

  task automatic read1();
    idle(); a_v[1] = 4'h5; step();
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst_chk", chk_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_fail", fail, 0);

    // Single write then matching read.
    write0(2'b11, 16'hA5A5);
    read1();
    idle(); gold_v[1] = 16'hA5A5; gate_v[1] = 16'hA5A5; step();
    chk("match_chk", chk_cnt, 1);
    chk("match_fail", fail, 0);

    // Single write then mismatching read on port 1.
    do_reset();
    write0(2'b11, 16'hA5A5);
    read1();
    chk("mis_pre_fail", fail, 0);
    idle(); gold_v[1] = 16'hA5A5; gate_v[1] = 16'hA5A4; step();
    chk("mis_fail", fail, 1);
    chk("mis_port", fail_port, 1);
    chk("mis_err", err_cnt, 1);
    idle(); step();
    chk("mis_hold_port", fail_port, 1);

    // Collision clears the lane, so a later read is not checked.
    do_reset();
    write0(2'b01, 16'h00AA);
    idle(); a_v[0] = 4'h5; a_v[1] = 4'h5; we_v = 2'b11; be_v[0] = 2'b01; be_v[1] = 2'b01;
    wd_v[0] = 16'h0011; wd_v[1] = 16'h0022; step();
    read1();
    idle(); gold_v[1] = 16'h1111; gate_v[1] = 16'h2222; step();
    idle(); step();
    chk("coll_chk", chk_cnt, 0);
    chk("coll_err", err_cnt, 0);

    // Only lane 1 known: a lane-0 difference is ignored.
    do_reset();
    write0(2'b10, 16'h1234);
    read1();
    idle(); gold_v[1] = 16'h12FF; gate_v[1] = 16'h1200; step();
    chk("lane_chk", chk_cnt, 1);
    chk("lane_err", err_cnt, 0);
    chk("lane_fail", fail, 0);

    // Reset pulse while a check is in flight discards it.
    do_reset();
    write0(2'b11, 16'hA5A5);
    read1();
    idle(); rst = 1'b1; gold_v[1] = 16'hFFFF; gate_v[1] = 16'h0000; step();
    for (int i = 0; i < 3; i++) begin idle(); gold_v[1] = 16'hFFFF; step(); end
    chk("flight_chk", chk_cnt, 0);
    chk("flight_fail", fail, 0);

    // Random traffic concentrated on the watched address.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      watch = 4'h5;
      for (int p = 0; p < 2; p++) begin
        a_v[p]  = ($urandom_range(0, 9) < 6) ? 4'h5 : 4'($urandom_range(0, 15));
        we_v[p] = ($urandom_range(0, 3) == 0);
        be_v[p] = 2'($urandom_range(0, 3));
        wd_v[p] = 16'($urandom);
        gold_v[p] = 16'($urandom);
        gate_v[p] = gold_v[p] ^ (($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'h0000);
      end
      step();
    end

    // Saturation: both ports mismatch every cycle.
    do_reset();
    write0(2'b11, 16'hA5A5);
    for (int i = 0; i < 32770; i++) begin
      idle(); a_v[0] = 4'h5; a_v[1] = 4'h5;
      gold_v[0] = 16'h0000; gate_v[0] = 16'hFFFF;
      gold_v[1] = 16'h0000; gate_v[1] = 16'hFFFF;
      step();
    end
    idle(); step();
    chk("sat_err", err_cnt, 16'hFFFF);
    chk("sat_chk", chk_cnt, 16'hFFFF);
    chk("sat_fail", fail, 1);
    chk("sat_port", fail_port, 0);

`ifdef BRAM_CHK_SHADOW_EN
    // Gold and gate agree but both differ from the written value.
    do_reset();
    write0(2'b11, 16'hA5A5);
    read1();
    idle(); step();
    chk("shadow_fail", fail, 1);
    chk("shadow_port", fail_port, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
